// File: rtl/mem_burst_ctrl.sv
// Byte-serial controller between the core and the 8-bit unified RAM: sized loads/stores
// for the LSB, whole-line bursts for the icache, I/O back-pressure and flush handling.
module mem_burst_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     lsb_need,
    input  logic                     lsb_store,
    input  logic [ADDR_W-1:0]        lsb_addr,
    input  logic [31:0]              lsb_data,
    input  logic [1:0]               lsb_size,
    input  logic                     lsb_unsigned,
    output logic                     lsb_val_ready,
    output logic [31:0]              lsb_val,
    input  logic                     icache_need,
    input  logic [ADDR_W-1:0]        icache_addr,
    output logic                     icache_ready,
    output logic [32*LINE_WORDS-1:0] icache_line,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int LINE_BYTES = 4 * LINE_WORDS;
    localparam int CNT_W      = $clog2(LINE_BYTES) + 1;
    localparam int LINE_W     = 32 * LINE_WORDS;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        FETCH = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    total_r;
    logic [ADDR_W-1:0]   base_r;
    logic [31:0]         data_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic                pend_r;
    logic [LINE_W-1:0]   buf_r;

    logic [CNT_W-1:0]    cap_idx_s;
    logic                cap_en_s;
    logic [LINE_W-1:0]   asm_s;
    logic [CNT_W-1:0]    written_s;
    logic                io_block_s;

    function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
        logic [CNT_W-1:0] n;
        case (size)
            2'd0:    n = CNT_W'(1);
            2'd1:    n = CNT_W'(2);
            default: n = CNT_W'(4);
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] res;
        case (size)
            2'd0:    res = uns ? {24'h000000, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = uns ? {16'h0000, raw[15:0]}   : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] data, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

    // Byte assembly and store progress; pend_r marks a byte already consumed during a stall.
    always_comb begin
        cap_idx_s = cnt_r - CNT_ONE;
        cap_en_s  = ((state_r == LOAD) || (state_r == FETCH)) && (cnt_r != CNT_ZERO) && !pend_r;
        asm_s     = buf_r;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (cap_en_s && (cap_idx_s == CNT_W'(i))) begin
                asm_s[8*i +: 8] = mem_din;
            end else begin
                asm_s[8*i +: 8] = buf_r[8*i +: 8];
            end
        end
        if (mem_wr || pend_r) begin
            written_s = cnt_r + CNT_ONE;
        end else begin
            written_s = cnt_r;
        end
        io_block_s = (base_r[17:16] == 2'b11) && io_buffer_full;
    end

    // Main FSM with all outputs registered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            total_r       <= CNT_ZERO;
            base_r        <= {ADDR_W{1'b0}};
            data_r        <= 32'h0000_0000;
            size_r        <= 2'd0;
            uns_r         <= 1'b0;
            pend_r        <= 1'b0;
            buf_r         <= {LINE_W{1'b0}};
            lsb_val_ready <= 1'b0;
            lsb_val       <= 32'h0000_0000;
            icache_ready  <= 1'b0;
            icache_line   <= {LINE_W{1'b0}};
            mem_dout      <= 8'h00;
            mem_a         <= {ADDR_W{1'b0}};
            mem_wr        <= 1'b0;
        end else if (!rdy_in) begin
            // Frozen: the byte returned in the first frozen cycle (or the write just made) is
            // remembered so that the resumed burst neither loses nor repeats it.
            mem_wr <= 1'b0;
            if ((state_r != IDLE) && !pend_r) begin
                if (state_r == STORE) begin
                    pend_r <= mem_wr;
                end else begin
                    pend_r <= cap_en_s;
                    buf_r  <= asm_s;
                end
            end
        end else begin
            pend_r        <= 1'b0;
            lsb_val_ready <= 1'b0;
            icache_ready  <= 1'b0;
            case (state_r)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (!lsb_val_ready && !icache_ready && !clear_in) begin
                        if (lsb_need) begin
                            base_r  <= lsb_addr;
                            data_r  <= lsb_data;
                            size_r  <= lsb_size;
                            uns_r   <= lsb_unsigned;
                            total_r <= size_bytes(lsb_size);
                            cnt_r   <= CNT_ZERO;
                            mem_a   <= lsb_addr;
                            if (lsb_store) begin
                                state_r  <= STORE;
                                mem_dout <= lsb_data[7:0];
                                mem_wr   <= !((lsb_addr[17:16] == 2'b11) && io_buffer_full);
                            end else begin
                                state_r <= LOAD;
                            end
                        end else if (icache_need) begin
                            state_r <= FETCH;
                            base_r  <= icache_addr;
                            total_r <= CNT_W'(LINE_BYTES);
                            cnt_r   <= CNT_ZERO;
                            mem_a   <= icache_addr;
                        end
                    end
                end
                LOAD, FETCH: begin
                    mem_wr <= 1'b0;
                    if (clear_in) begin
                        state_r <= IDLE;
                    end else if (cnt_r == total_r) begin
                        state_r <= IDLE;
                        if (state_r == LOAD) begin
                            lsb_val_ready <= 1'b1;
                            lsb_val       <= extend_load(asm_s[31:0], size_r, uns_r);
                        end else begin
                            icache_ready <= 1'b1;
                            icache_line  <= asm_s;
                        end
                    end else begin
                        buf_r <= asm_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        mem_a <= base_r + ADDR_W'(cnt_r + CNT_ONE);
                    end
                end
                STORE: begin
                    if (written_s == total_r) begin
                        state_r       <= IDLE;
                        lsb_val_ready <= 1'b1;
                        mem_wr        <= 1'b0;
                    end else begin
                        cnt_r    <= written_s;
                        mem_a    <= base_r + ADDR_W'(written_s);
                        mem_dout <= store_byte(data_r, written_s[1:0]);
                        mem_wr   <= !io_block_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a free-running synchronous byte RAM.
module tb_mem_burst_ctrl;

    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 4;

    logic         clk_in = 1'b0;
    logic         rst_in, rdy_in, clear_in;
    logic         lsb_need, lsb_store, lsb_unsigned;
    logic [31:0]  lsb_addr, lsb_data;
    logic [1:0]   lsb_size;
    logic         lsb_val_ready;
    logic [31:0]  lsb_val;
    logic         icache_need;
    logic [31:0]  icache_addr;
    logic         icache_ready;
    logic [127:0] icache_line;
    logic [7:0]   mem_din, mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full;

    logic [7:0]   ram [0:4095];
    logic         tb_we = 1'b0;
    logic [11:0]  tb_wa = 12'h000;
    logic [7:0]   tb_wd = 8'h00;
    logic [127:0] exp_line;

    int n_checks = 0;
    int n_fail   = 0;

    mem_burst_ctrl #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .lsb_need(lsb_need), .lsb_store(lsb_store), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
        .lsb_size(lsb_size), .lsb_unsigned(lsb_unsigned), .lsb_val_ready(lsb_val_ready),
        .lsb_val(lsb_val), .icache_need(icache_need), .icache_addr(icache_addr),
        .icache_ready(icache_ready), .icache_line(icache_line), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (tb_we) ram[tb_wa] <= tb_wd;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk_in); @(negedge clk_in);
        tb_we = 1'b0;
    endtask

    task automatic req_lsb(input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input bit uns);
        lsb_store = st; lsb_addr = a; lsb_data = d; lsb_size = sz; lsb_unsigned = uns;
        lsb_need = 1'b1;
    endtask

    // Counts edges (acceptance edge included) until the selected pulse, then idles one cycle.
    task automatic wait_ready(input bit icache, output int cyc, output bit ok, output int wr_cnt);
        cyc = 0; ok = 1'b0; wr_cnt = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk_in); @(negedge clk_in);
            cyc++;
            if (mem_wr) wr_cnt++;
            if (icache ? icache_ready : lsb_val_ready) begin
                ok = 1'b1;
                if (icache) icache_need = 1'b0;
                else lsb_need = 1'b0;
            end
        end
        @(posedge clk_in); @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b0; clear_in = 1'b1;
        lsb_need = 1'b0; icache_need = 1'b0; io_buffer_full = 1'b0;
        lsb_store = 1'b0; lsb_addr = 32'h0; lsb_data = 32'h0; lsb_size = 2'd0; lsb_unsigned = 1'b0;
        icache_addr = 32'h0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        n_checks++; if (lsb_val_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lsb_ready got %b want 0", lsb_val_ready); end
        n_checks++; if (icache_ready !== 1'b0) begin n_fail++; $display("FAIL reset_icache_ready got %b want 0", icache_ready); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_checks++; if (lsb_val !== 32'h0) begin n_fail++; $display("FAIL reset_lsb_val got %h want 0", lsb_val); end
        n_checks++; if (icache_line !== 128'h0) begin n_fail++; $display("FAIL reset_icache_line got %h want 0", icache_line); end
        n_checks++; if ({mem_a, mem_dout} !== 40'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_a, mem_dout); end
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    endtask

    task automatic setup_ram();
        poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
        poke(12'h120, 8'h80);
        poke(12'h130, 8'h01); poke(12'h131, 8'h80);
        for (int i = 0; i < 16; i++) begin
            poke(12'(i), 8'(i * 7 + 3));
            exp_line[8*i +: 8] = 8'(i * 7 + 3);
            poke(12'(32'h40 + i), 8'(i + 8'h90));
        end
    endtask

    task automatic test_word_load();
        int cyc, wrc; bit ok;
        req_lsb(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL word_load_timeout no lsb_val_ready"); end
        n_checks++; if (lsb_val !== 32'h44332211) begin n_fail++; $display("FAIL word_load_val got %h want 44332211", lsb_val); end
        // acceptance edge + 5
        n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL word_load_latency got %0d want 6", cyc); end
        n_checks++; if (wrc != 0) begin n_fail++; $display("FAIL word_load_mem_wr got %0d writes want 0", wrc); end
    endtask

    task automatic test_load_extend();
        logic [31:0] t_addr [4] = '{32'h120, 32'h120, 32'h130, 32'h130};
        logic [1:0]  t_size [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        bit          t_uns  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001, 32'hFFFF8001};
        int          t_cyc  [4] = '{3, 3, 4, 4};
        int cyc, wrc; bit ok;
        for (int i = 0; i < 4; i++) begin
            req_lsb(1'b0, t_addr[i], 32'h0, t_size[i], t_uns[i]);
            wait_ready(1'b0, cyc, ok, wrc);
            n_checks++;
            if (!ok || lsb_val !== t_exp[i] || cyc != t_cyc[i]) begin
                n_fail++;
                $display("FAIL extend_%0d got val %h cyc %0d ok %b want %h cyc %0d", i, lsb_val, cyc, ok, t_exp[i], t_cyc[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int cyc, wrc; bit ok;
        icache_addr = 32'h0;
        icache_need = 1'b1;
        req_lsb(1'b1, 32'h200, 32'hDEADBEEF, 2'd2, 1'b0);
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (!ok || cyc != 5) begin n_fail++; $display("FAIL sim_store_latency got %0d ok %b want 5", cyc, ok); end
        n_checks++; if (wrc != 4) begin n_fail++; $display("FAIL sim_store_writes got %0d want 4", wrc); end
        n_checks++; if ({ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sim_store_ram got %h%h%h%h want DEADBEEF", ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]);
        end
        n_checks++; if (icache_ready !== 1'b0) begin n_fail++; $display("FAIL sim_icache_early got %b want 0", icache_ready); end
        wait_ready(1'b1, cyc, ok, wrc);
        // edge after the LSB pulse is blocked, so the fetch is accepted one edge later
        n_checks++; if (!ok || cyc != 18) begin n_fail++; $display("FAIL sim_fetch_latency got %0d ok %b want 18", cyc, ok); end
        n_checks++; if (icache_line !== exp_line) begin n_fail++; $display("FAIL sim_fetch_line got %h want %h", icache_line, exp_line); end
        n_checks++; if (wrc != 0) begin n_fail++; $display("FAIL sim_fetch_mem_wr got %0d want 0", wrc); end
    endtask

    task automatic test_clear();
        int cyc, wrc; bit ok, found, seen_rdy, seen_wr;
        found = 1'b0; seen_rdy = 1'b0; seen_wr = 1'b0;
        icache_addr = 32'h40;
        icache_need = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_a == 32'h47) begin
                found = 1'b1; clear_in = 1'b1; icache_need = 1'b0;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL clear_byte7_reached got 0 want 1"); end
        @(posedge clk_in); @(negedge clk_in);
        clear_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (icache_ready) seen_rdy = 1'b1;
            if (mem_wr) seen_wr = 1'b1;
            @(posedge clk_in); @(negedge clk_in);
        end
        n_checks++; if (seen_rdy || seen_wr) begin n_fail++; $display("FAIL clear_fetch_quiet got rdy %b wr %b want 0 0", seen_rdy, seen_wr); end
        n_checks++; if (icache_line !== exp_line) begin n_fail++; $display("FAIL clear_line_held got %h want %h", icache_line, exp_line); end
        req_lsb(1'b0, 32'h120, 32'h0, 2'd0, 1'b0);
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (!ok || cyc != 3 || lsb_val !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL clear_then_load got cyc %0d val %h want 3 FFFFFF80", cyc, lsb_val);
        end
        req_lsb(1'b1, 32'h210, 32'h11223344, 2'd2, 1'b0);
        @(posedge clk_in); @(negedge clk_in);
        clear_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        clear_in = 1'b0;
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (!ok || cyc != 3) begin n_fail++; $display("FAIL clear_store_latency got %0d ok %b want 3", cyc, ok); end
        n_checks++; if ({ram[12'h213], ram[12'h212], ram[12'h211], ram[12'h210]} !== 32'h11223344) begin
            n_fail++; $display("FAIL clear_store_ram got %h%h%h%h want 11223344", ram[12'h213], ram[12'h212], ram[12'h211], ram[12'h210]);
        end
    endtask

    task automatic test_rdy_stall();
        int cyc, wrc; bit ok, moved;
        moved = 1'b0;
        req_lsb(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
        n_checks++; if (mem_a !== 32'h101) begin n_fail++; $display("FAIL stall_addr_before got %h want 101", mem_a); end
        rdy_in = 1'b0;
        repeat (3) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_a !== 32'h101 || mem_wr !== 1'b0 || lsb_val_ready !== 1'b0) moved = 1'b1;
        end
        n_checks++; if (moved) begin n_fail++; $display("FAIL stall_frozen got change at %h want hold at 101", mem_a); end
        rdy_in = 1'b1;
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (lsb_val !== 32'h44332211) begin n_fail++; $display("FAIL stall_load_val got %h want 44332211", lsb_val); end
        // 2 + 3 frozen + 4 = uninterrupted 6 + 3
        n_checks++; if (!ok || cyc != 4) begin n_fail++; $display("FAIL stall_latency got %0d ok %b want 4", cyc, ok); end
    endtask

    task automatic test_io_stall();
        bit seen_wr, early;
        seen_wr = 1'b0; early = 1'b0;
        io_buffer_full = 1'b1;
        req_lsb(1'b1, 32'h30000, 32'h00000041, 2'd0, 1'b0);
        repeat (6) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_wr) seen_wr = 1'b1;
            if (lsb_val_ready) early = 1'b1;
        end
        n_checks++; if (seen_wr || early) begin n_fail++; $display("FAIL io_stall_hold got wr %b rdy %b want 0 0", seen_wr, early); end
        io_buffer_full = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h41}) begin
            n_fail++; $display("FAIL io_write got wr %b a %h d %h want 1 30000 41", mem_wr, mem_a, mem_dout);
        end
        @(posedge clk_in); @(negedge clk_in);
        n_checks++; if (lsb_val_ready !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL io_done got rdy %b wr %b want 1 0", lsb_val_ready, mem_wr);
        end
        lsb_need = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        n_checks++; if (ram[12'h000] !== 8'h41) begin n_fail++; $display("FAIL io_ram got %h want 41", ram[12'h000]); end
    endtask

    task automatic test_reset_midop();
        int cyc, wrc; bit ok;
        req_lsb(1'b1, 32'h220, 32'hAABBCCDD, 2'd2, 1'b0);
        repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
        rdy_in = 1'b0; rst_in = 1'b1; lsb_need = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        n_checks++; if ({mem_wr, mem_a, mem_dout, lsb_val} !== 73'h0) begin
            n_fail++; $display("FAIL midop_reset got wr %b a %h d %h val %h want all 0", mem_wr, mem_a, mem_dout, lsb_val);
        end
        rst_in = 1'b0; rdy_in = 1'b1;
        req_lsb(1'b0, 32'h120, 32'h0, 2'd0, 1'b1);
        wait_ready(1'b0, cyc, ok, wrc);
        n_checks++; if (!ok || cyc != 3 || lsb_val !== 32'h00000080) begin
            n_fail++; $display("FAIL midop_after got cyc %0d val %h want 3 00000080", cyc, lsb_val);
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        setup_ram();
        test_word_load();
        test_load_extend();
        test_simultaneous();
        test_clear();
        test_rdy_stall();
        test_io_stall();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
